// File: rtl/mult.sv
// Iterative unsigned 16x16 shift-and-add multiplier, low 16 bits of product, start/done handshake.
// Optional MULT_OVF_EN adds an ovf output flagging a nonzero upper product half.
module mult (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] in1,
  input  logic [15:0] in2,
  input  logic        start,
`ifdef MULT_OVF_EN
  output logic        ovf,
`endif
  output logic [15:0] Result,
  output logic        busy,
  output logic        done
);

  typedef enum logic {IDLE, RUN} state_e;

  state_e      state_q, state_d;
  logic [31:0] mcand_q, mcand_d;
  logic [15:0] mplier_q, mplier_d;
  logic [31:0] acc_q, acc_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [15:0] result_q, result_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [31:0] acc_sum;
`ifdef MULT_OVF_EN
  logic        ovf_q, ovf_d;
`endif

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
`ifdef MULT_OVF_EN
    ovf_d    = ovf_q;
`endif
    // Partial product for this iteration; also used to form the final result on the last edge.
    acc_sum  = acc_q + (mplier_q[0] ? mcand_q : 32'd0);
    case (state_q)
      IDLE: begin
        if (start) begin
          mcand_d  = {16'd0, in1};
          mplier_d = in2;
          acc_d    = 32'd0;
          cnt_d    = 5'd0;
          busy_d   = 1'b1;
          state_d  = RUN;
        end
      end
      RUN: begin
        acc_d    = acc_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 5'd1;
        if (cnt_q == 5'd15) begin
          result_d = acc_sum[15:0];
`ifdef MULT_OVF_EN
          ovf_d    = |acc_sum[31:16];
`endif
          done_d   = 1'b1;
          busy_d   = 1'b0;
          state_d  = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      mcand_q  <= 32'd0;
      mplier_q <= 16'd0;
      acc_q    <= 32'd0;
      cnt_q    <= 5'd0;
      result_q <= 16'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef MULT_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef MULT_OVF_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign Result = result_q;
  assign busy   = busy_q;
  assign done   = done_q;
`ifdef MULT_OVF_EN
  assign ovf    = ovf_q;
`endif

endmodule

// File: tb/tb_mult.sv
// Scoreboard bench for mult: driver pushes expected results with accept time, monitor pops on done.
module tb_mult;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] in1 = 16'd0;
  logic [15:0] in2 = 16'd0;
  logic        start = 1'b0;
  logic [15:0] Result;
  logic        busy;
  logic        done;
  logic        ovf_w;

  mult dut (
    .clk   (clk),
    .rst_n (rst_n),
    .in1   (in1),
    .in2   (in2),
    .start (start),
`ifdef MULT_OVF_EN
    .ovf   (ovf_w),
`endif
    .Result(Result),
    .busy  (busy),
    .done  (done)
  );

`ifndef MULT_OVF_EN
  assign ovf_w = 1'b0;
`endif

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] res;
    logic        ovf;
    longint      t0;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  logic done_prev = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Reference: plain 32-bit product, truncated for Result, upper half for ovf.
  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input longint t0);
    exp_t e;
    logic [31:0] p;
    p    = {16'd0, a} * {16'd0, b};
    e.res = p[15:0];
    e.ovf = |p[31:16];
    e.t0  = t0;
    return e;
  endfunction

  // Monitor: done is sampled at the negedge after E16, i.e. accept time + 165.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      chk("done_one_cycle", {31'd0, done_prev}, 32'd0);
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual=done with Result %0h expected=no done", Result);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result", {16'd0, Result}, {16'd0, e.res});
        chk("latency", 32'($time - e.t0), 32'd165);
`ifdef MULT_OVF_EN
        chk("ovf", {31'd0, ovf_w}, {31'd0, e.ovf});
`endif
      end
    end
    done_prev = (done === 1'b1);
  end

  // Called at a negedge with the DUT idle; start is taken at the next posedge.
  task automatic issue(input logic [15:0] a, input logic [15:0] b);
    in1   = a;
    in2   = b;
    start = 1'b1;
    sb.push_back(model(a, b, $time + 5));
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("busy_after_accept", {31'd0, busy}, 32'd1);
    in1 = 16'($urandom);
    in2 = 16'($urandom);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("scoreboard_drained", sb.size(), 32'd0);
    @(negedge clk);
  endtask

  logic [15:0] da [7] = '{16'd2, 16'd5, 16'd6, 16'd25, 16'd250, 16'd1, 16'd300};
  logic [15:0] db [7] = '{16'd3, 16'd5, 16'd6, 16'd10, 16'd100, 16'd1, 16'd3};

  initial begin
    longint t;
    logic [15:0] ra, rb;

    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_result", {16'd0, Result}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
`ifdef MULT_OVF_EN
    chk("reset_ovf", {31'd0, ovf_w}, 32'd0);
`endif

    for (int i = 0; i < 7; i++) begin
      issue(da[i], db[i]);
      wait_drain();
    end

    issue(16'hFFFF, 16'hFFFF); wait_drain();
    issue(16'd256, 16'd256);   wait_drain();
    issue(16'd0, 16'hFFFF);    wait_drain();

    // Extra start and operand changes mid-run must be ignored.
    issue(16'd7, 16'd9);
    repeat (5) @(negedge clk);
    in1 = 16'd3; in2 = 16'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_drain();
    repeat (20) @(negedge clk);
    chk("result_hold", {16'd0, Result}, 32'd63);

    // Reset in the middle of a run aborts it silently.
    issue(16'd250, 16'd100);
    repeat (7) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_result", {16'd0, Result}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    repeat (25) @(negedge clk);
    issue(16'd5, 16'd5);
    wait_drain();

    // start held high: accepts every 17 cycles.
    in1 = 16'd6; in2 = 16'd6; start = 1'b1;
    t = $time + 5;
    for (int k = 0; k < 3; k++) sb.push_back(model(16'd6, 16'd6, t + 170 * k));
    repeat (40) @(negedge clk);
    start = 1'b0;
    wait_drain();
    repeat (20) @(negedge clk);

    for (int k = 0; k < 25; k++) begin
      ra = ($urandom_range(0, 4) == 0) ? 16'hFFFF : 16'($urandom);
      rb = ($urandom_range(0, 4) == 0) ? 16'($urandom_range(0, 3)) : 16'($urandom);
      issue(ra, rb);
      wait_drain();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
